dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares one single-port data memory between two requesters: the fetch stage (read-only instruction-word port) and the memory stage (mrmovq/popq/ret reads; rmmovq/pushq/call writes).
- Sits between the pipeline stages and the memory array, and sequences each access over a fixed-latency memory.
- Returns a one-cycle done pulse per transaction; stage stalls are derived from it.
- Flags out-of-range addresses so the pipeline can raise the ADR status.

Parameters:
- DEPTH, 128, number of 64-bit words in the memory; legal addresses are 0..DEPTH-1.
- MEM_LAT, 2, cycles from mem_en to valid mem_rdata; must be >= 1.
- MAX_STREAK, 4, maximum consecutive memory-stage grants while fetch is pending.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- f_req  input  1  fetch read request; held until f_done
- f_addr  input  64  fetch word address; stable while f_req
- f_rdata  output  64  fetch read data; valid with f_done
- f_done  output  1  one-cycle completion pulse, fetch
- f_err  output  1  fetch address out of range; valid with f_done
- m_req  input  1  memory-stage request; held until m_done
- m_we  input  1  1 = write, 0 = read
- m_addr  input  64  memory-stage word address
- m_wdata  input  64  write data
- m_rdata  output  64  read data; valid with m_done
- m_done  output  1  one-cycle completion pulse, memory stage
- m_err  output  1  address out of range; valid with m_done
- mem_en  output  1  memory access strobe, one cycle per access
- mem_we  output  1  write enable, qualified by mem_en
- mem_addr  output  $clog2(DEPTH)  memory address
- mem_wdata  output  64  memory write data
- mem_rdata  input  64  memory read data; valid MEM_LAT cycles after mem_en

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: all outputs 0; FSM in IDLE; streak counter 0. Reset mid-transaction abandons the access, no done is issued, and any in-flight mem_rdata is ignored.
- FSM states: IDLE, WAIT, RESP.
- IDLE: samples the requests and picks a winner.
  - Memory stage wins by default.
  - Fetch wins if it is the only requester, or if streak == MAX_STREAK and f_req=1.
- Accepted legal address (addr < DEPTH):
  - Same cycle: mem_en=1; mem_addr = addr[$clog2(DEPTH)-1:0]; mem_we = m_we (fetch: 0); mem_wdata = m_wdata.
  - Go to WAIT and load the latency counter with MEM_LAT-1.
- Accepted illegal address (addr >= DEPTH, compared on the full 64 bits):
  - No mem_en.
  - Next cycle: done=1, err=1, rdata=0.
  - Writes to illegal addresses are discarded.
- WAIT: counter decrements; at 0 go to RESP, where the winner's done=1, err=0 and rdata = mem_rdata. Writes also report done at MEM_LAT, with rdata=0.
- Latency: legal access done at t+MEM_LAT, where t is the accept cycle; illegal access done at t+1.
- RESP always returns to IDLE. The next accept can be the cycle after done, so back-to-back throughput is one access per MEM_LAT+1 cycles.
- rdata/err registered: they hold their value until the next done on that port; done is high for exactly one cycle.
- Streak counter:
  - +1 (saturating at MAX_STREAK) on each memory-stage grant while f_req=1.
  - Cleared on a fetch grant, or in any IDLE cycle with f_req=0.
- Simultaneous requests in the same IDLE cycle: exactly one is granted; the loser keeps req high and is served later.
- Requester protocol: req/addr/we/wdata must stay stable until done. Deasserting req before done is illegal; the arbiter completes the access regardless.
- Only one transaction is ever outstanding; a single-port memory is never given two overlapping mem_en cycles.

Decomposition:
- Shared package y86_mem_pkg:
  - FSM state enum.
  - Requester ID enum (REQ_F, REQ_M).
  - Y86 icode constants used for request generation (MRMOVQ=4'h5, RMMOVQ=4'h4, CALL=4'h8, RET=4'h9, PUSHQ=4'hA, POPQ=4'hB).
  - STAT_ADR encoding.
- One natural sub-module: dmem_lat_counter, the loadable down-counter with zero flag. Everything else stays flat.

Test Plan:
- Reset, then fetch-only read with f_addr=5 and mem word 5 = 64'hDEAD_BEEF → mem_en at t; f_done=1 and f_rdata=64'hDEAD_BEEF at t+2; m_done stays 0.
- m_req write (m_addr=10, m_wdata=64'h1234), then m_req read of addr 10 → write done at t+2; read accepted t+3, m_rdata=64'h1234 at t+5.
- f_req and m_req both asserted in the same cycle → memory stage is granted first; fetch done follows its done by MEM_LAT+1 cycles.
- f_req held high while 6 back-to-back m_req reads are issued → fetch is granted after exactly 4 memory-stage grants (MAX_STREAK=4).
- m_addr=200 write, then f_addr=64'hFFFF_FFFF_FFFF_FFFF read → no mem_en; m_done=1, m_err=1 one cycle after accept; f_err=1, f_rdata=0.
- reset asserted in the cycle after accept of a read → no done pulse; all outputs 0 next cycle; a fresh request afterwards completes normally in MEM_LAT cycles.

Source files
------------

// File: rtl/y86_mem_pkg.sv
// Shared types and constants for the Y86 data-memory path: arbiter FSM
// states, requester IDs, memory-touching icodes and the ADR status code.
package y86_mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_F = 1'b0,
        REQ_M = 1'b1
    } req_id_e;

    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_ADR = 3'd3;

    function automatic logic icode_writes(input logic [3:0] icode);
        return (icode == I_RMMOVQ) || (icode == I_PUSHQ) || (icode == I_CALL);
    endfunction

    function automatic logic [2:0] access_stat(input logic err);
        return err ? STAT_ADR : STAT_AOK;
    endfunction

endpackage

// File: rtl/dmem_lat_counter.sv
// Loadable down-counter that times the WAIT phase of a memory access;
// expire marks the WAIT cycle whose decrement reaches zero.
module dmem_lat_counter #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         expire
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expire = dec && (cnt == W'(1));

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter (fetch, memory stage) in front of a single-port,
// fixed-latency data memory with out-of-range address reporting.
module dmem_arbiter
    import y86_mem_pkg::*;
#(
    parameter int DEPTH      = 128,
    parameter int MEM_LAT    = 2,
    parameter int MAX_STREAK = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     f_req,
    input  logic [63:0]              f_addr,
    output logic [63:0]              f_rdata,
    output logic                     f_done,
    output logic                     f_err,
    input  logic                     m_req,
    input  logic                     m_we,
    input  logic [63:0]              m_addr,
    input  logic [63:0]              m_wdata,
    output logic [63:0]              m_rdata,
    output logic                     m_done,
    output logic                     m_err,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [$clog2(DEPTH)-1:0] mem_addr,
    output logic [63:0]              mem_wdata,
    input  logic [63:0]              mem_rdata
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam logic [CW-1:0] LAT_LOAD   = CW'(MEM_LAT - 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

    arb_state_e    state;
    req_id_e       owner;
    logic          err_q;
    logic          we_q;
    logic [SW-1:0] streak;
    logic [63:0]   f_rdata_q;
    logic [63:0]   m_rdata_q;
    logic          f_err_q;
    logic          m_err_q;

    logic          grant_f;
    logic          accept;
    logic          sel_legal;
    logic [63:0]   sel_addr;
    logic [63:0]   resp_data;
    logic          lat_expire;
    logic          resp;

    // Fetch only overrides the memory stage once the streak limit is hit.
    always_comb begin
        grant_f   = f_req && (!m_req || streak == STREAK_MAX);
        sel_addr  = grant_f ? f_addr : m_addr;
        sel_legal = sel_addr < 64'(DEPTH);
        accept    = !reset && (state == S_IDLE) && (f_req || m_req);
    end

    assign mem_en    = accept && sel_legal;
    assign mem_we    = mem_en && !grant_f && m_we;
    assign mem_addr  = mem_en ? sel_addr[AW-1:0] : '0;
    assign mem_wdata = (mem_en && !grant_f) ? m_wdata : '0;

    // Writes and rejected addresses return zero data.
    assign resp      = (state == S_RESP);
    assign resp_data = (err_q || we_q) ? '0 : mem_rdata;
    assign f_done    = resp && (owner == REQ_F);
    assign m_done    = resp && (owner == REQ_M);
    assign f_rdata   = f_done ? resp_data : f_rdata_q;
    assign f_err     = f_done ? err_q : f_err_q;
    assign m_rdata   = m_done ? resp_data : m_rdata_q;
    assign m_err     = m_done ? err_q : m_err_q;

    dmem_lat_counter #(
        .W(CW)
    ) u_lat (
        .clk      (clk),
        .reset    (reset),
        .load     (mem_en),
        .load_val (LAT_LOAD),
        .dec      (state == S_WAIT),
        .expire   (lat_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            owner     <= REQ_F;
            err_q     <= 1'b0;
            we_q      <= 1'b0;
            streak    <= '0;
            f_rdata_q <= '0;
            f_err_q   <= 1'b0;
            m_rdata_q <= '0;
            m_err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        owner <= grant_f ? REQ_F : REQ_M;
                        err_q <= !sel_legal;
                        we_q  <= !grant_f && m_we;
                        state <= (!sel_legal || MEM_LAT == 1) ? S_RESP : S_WAIT;
                    end
                    if ((accept && grant_f) || !f_req) begin
                        streak <= '0;
                    end else if (accept && streak != STREAK_MAX) begin
                        streak <= streak + SW'(1);
                    end
                end
                S_WAIT: begin
                    if (lat_expire) begin
                        state <= S_RESP;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
            if (f_done) begin
                f_rdata_q <= resp_data;
                f_err_q   <= err_q;
            end
            if (m_done) begin
                m_rdata_q <= resp_data;
                m_err_q   <= err_q;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, each cycle
// compared against a transaction-level model of arbitration and latency.
module tb_dmem_arbiter;
    import y86_mem_pkg::*;

    localparam int DEPTH      = 128;
    localparam int MEM_LAT    = 2;
    localparam int MAX_STREAK = 4;
    localparam int AW         = $clog2(DEPTH);

    logic          clk;
    logic          reset;
    logic          f_req;
    logic [63:0]   f_addr;
    logic [63:0]   f_rdata;
    logic          f_done;
    logic          f_err;
    logic          m_req;
    logic          m_we;
    logic [63:0]   m_addr;
    logic [63:0]   m_wdata;
    logic [63:0]   m_rdata;
    logic          m_done;
    logic          m_err;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [63:0]   mem_wdata;
    logic [63:0]   mem_rdata;

    dmem_arbiter #(
        .DEPTH      (DEPTH),
        .MEM_LAT    (MEM_LAT),
        .MAX_STREAK (MAX_STREAK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_rdata   (f_rdata),
        .f_done    (f_done),
        .f_err     (f_err),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .m_done    (m_done),
        .m_err     (m_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] init_word(input int a);
        if (a == 5) return 64'hDEAD_BEEF;
        return 64'hC0DE_0000_0000_0000 | (64'(a) * 64'h0001_0001);
    endfunction

    // Memory array with MEM_LAT read latency; idle read data is garbage.
    logic [63:0] tmem  [DEPTH];
    logic        twr   [DEPTH];
    logic [63:0] rpipe [MEM_LAT];

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            tmem[mem_addr] <= mem_wdata;
            twr[mem_addr]  <= 1'b1;
        end
        if (mem_en && !mem_we)
            rpipe[0] <= (twr[mem_addr] === 1'b1) ? tmem[mem_addr] : init_word(int'(mem_addr));
        else
            rpipe[0] <= 64'hBADD_F00D_BADD_F00D;
        for (int i = 1; i < MEM_LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata = rpipe[MEM_LAT-1];

    int n_tests;
    int n_fail;
    int cyc;

    logic        rst_stage;
    logic        f_pend;
    logic        m_pend;
    logic        m_we_v;
    logic [63:0] f_addr_v;
    logic [63:0] m_addr_v;
    logic [63:0] m_wdata_v;

    logic [63:0] rmem [DEPTH];
    bit          rwr  [DEPTH];
    bit          pend;
    int          done_cyc;
    bit          own_f;
    logic [63:0] cur_data;
    bit          cur_err;
    int          streak;
    logic [63:0] hf_rdata;
    logic [63:0] hm_rdata;
    bit          hf_err;
    bit          hm_err;
    int          last_f_dc;
    int          last_m_dc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue_f(input logic [63:0] a);
        f_pend   = 1'b1;
        f_addr_v = a;
    endtask

    task automatic issue_m(input logic we, input logic [63:0] a, input logic [63:0] d);
        m_pend    = 1'b1;
        m_we_v    = we;
        m_addr_v  = a;
        m_wdata_v = d;
    endtask

    // One clock: drive staged inputs, check outputs against the model, update it.
    task automatic tick();
        bit          ef, em, acc, gf, legal, wr, free;
        logic [63:0] a;
        int          idx;
        @(posedge clk);
        #1;
        reset   = rst_stage;
        f_req   = f_pend;
        f_addr  = f_addr_v;
        m_req   = m_pend;
        m_we    = m_we_v;
        m_addr  = m_addr_v;
        m_wdata = m_wdata_v;
        #1;
        cyc++;
        ef = pend && (cyc == done_cyc) && own_f;
        em = pend && (cyc == done_cyc) && !own_f;
        if (ef) begin hf_rdata = cur_data; hf_err = cur_err; last_f_dc = cyc; end
        if (em) begin hm_rdata = cur_data; hm_err = cur_err; last_m_dc = cyc; end
        free  = !pend;
        acc   = !reset && free && (f_req || m_req);
        gf    = f_req && (!m_req || streak >= MAX_STREAK);
        a     = gf ? f_addr : m_addr;
        legal = a < 64'(DEPTH);
        wr    = !gf && m_we;
        idx   = int'(a[AW-1:0]);

        chk("f_done", f_done, ef);
        chk("m_done", m_done, em);
        chk("f_rdata", f_rdata, hf_rdata);
        chk("f_err", f_err, hf_err);
        chk("m_rdata", m_rdata, hm_rdata);
        chk("m_err", m_err, hm_err);
        chk("mem_en", mem_en, acc && legal);
        if (acc && legal) begin
            chk("mem_addr", 64'(mem_addr), 64'(a[AW-1:0]));
            chk("mem_we", mem_we, wr);
            if (wr) chk("mem_wdata", mem_wdata, m_wdata);
        end

        if (ef || em) pend = 1'b0;
        if (acc) begin
            pend     = 1'b1;
            own_f    = gf;
            cur_err  = !legal;
            done_cyc = cyc + (legal ? MEM_LAT : 1);
            cur_data = '0;
            if (legal && !wr) cur_data = rwr[idx] ? rmem[idx] : init_word(idx);
            if (legal && wr) begin rmem[idx] = m_wdata; rwr[idx] = 1'b1; end
            if (gf) streak = 0;
            else if (f_req) streak = (streak < MAX_STREAK) ? streak + 1 : MAX_STREAK;
            else streak = 0;
        end else if (free && !reset && !f_req) begin
            streak = 0;
        end
        if (reset) begin
            pend = 1'b0; streak = 0;
            hf_rdata = '0; hm_rdata = '0; hf_err = 1'b0; hm_err = 1'b0;
        end

        if (f_done === 1'b1) f_pend = 1'b0;
        if (m_done === 1'b1) m_pend = 1'b0;
        if (reset) begin f_pend = 1'b0; m_pend = 1'b0; end
    endtask

    task automatic drain(input string tag, input int bound);
        for (int i = 0; i < bound && (f_pend || m_pend); i++) tick();
        chk(tag, {62'd0, f_pend, m_pend}, 64'd0);
    endtask

    function automatic logic [63:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return {$urandom, $urandom} | 64'h80;
        return 64'($urandom_range(0, 15));
    endfunction

    logic [3:0] icodes [6];
    logic [3:0] ic;
    int         t;
    int         m_issued;
    int         m_dones;
    int         m_before_f;
    bit         f_seen;

    initial begin
        icodes = '{I_MRMOVQ, I_RMMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ};
        n_tests = 0; n_fail = 0; cyc = 0;
        reset = 1'b1; f_req = 1'b0; f_addr = '0; m_req = 1'b0; m_we = 1'b0;
        m_addr = '0; m_wdata = '0;
        rst_stage = 1'b0; f_pend = 1'b0; m_pend = 1'b0; m_we_v = 1'b0;
        f_addr_v = '0; m_addr_v = '0; m_wdata_v = '0;
        for (int i = 0; i < DEPTH; i++) begin rwr[i] = 1'b0; rmem[i] = '0; end
        pend = 1'b0; done_cyc = 0; own_f = 1'b0; cur_data = '0; cur_err = 1'b0;
        streak = 0; hf_rdata = '0; hm_rdata = '0; hf_err = 1'b0; hm_err = 1'b0;
        last_f_dc = 0; last_m_dc = 0;
        repeat (2) @(posedge clk);

        // Reset state
        tick();
        chk("rst_f_done", f_done, 0);
        chk("rst_f_rdata", f_rdata, 0);
        chk("rst_f_err", f_err, 0);
        chk("rst_m_done", m_done, 0);
        chk("rst_m_rdata", m_rdata, 0);
        chk("rst_m_err", m_err, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", 64'(mem_addr), 0);
        chk("rst_mem_wdata", mem_wdata, 0);

        // Fetch-only read of word 5
        issue_f(64'd5); t = cyc + 1;
        drain("fetch_drain", 20);
        chk("fetch_latency", 64'(last_f_dc - t), 64'(MEM_LAT));
        chk("fetch_data", f_rdata, 64'hDEAD_BEEF);

        // Write then read back through the memory-stage port
        issue_m(1'b1, 64'd10, 64'h1234); t = cyc + 1;
        drain("wr_drain", 20);
        chk("wr_latency", 64'(last_m_dc - t), 64'(MEM_LAT));
        issue_m(1'b0, 64'd10, 64'd0);
        drain("rd_drain", 20);
        chk("rd_done_cycle", 64'(last_m_dc - t), 64'd5);
        chk("rd_data", m_rdata, 64'h1234);

        // Simultaneous requests: memory stage first
        issue_f(64'd7); issue_m(1'b0, 64'd20, 64'd0);
        drain("both_drain", 30);
        chk("both_m_first", 64'(last_m_dc < last_f_dc), 64'd1);
        chk("both_gap", 64'(last_f_dc - last_m_dc), 64'(MEM_LAT + 1));

        // Fetch held against six back-to-back memory-stage reads
        issue_f(64'd3); issue_m(1'b0, 64'd40, 64'd0);
        m_issued = 1; m_dones = 0; m_before_f = -1; f_seen = 1'b0;
        for (int i = 0; i < 100 && (!f_seen || m_dones < 6); i++) begin
            tick();
            if (f_done === 1'b1) begin f_seen = 1'b1; m_before_f = m_dones; end
            if (m_done === 1'b1) begin
                m_dones++;
                if (m_issued < 6) begin issue_m(1'b0, 64'(40 + m_issued), 64'd0); m_issued++; end
            end
        end
        chk("streak_m_before_f", 64'(m_before_f), 64'(MAX_STREAK));
        chk("streak_all_m", 64'(m_dones), 64'd6);

        // Out-of-range addresses
        issue_m(1'b1, 64'd200, 64'h5555); t = cyc + 1;
        drain("ill_m_drain", 10);
        chk("ill_m_latency", 64'(last_m_dc - t), 64'd1);
        chk("ill_m_err", m_err, 1);
        chk("ill_m_stat", 64'(access_stat(m_err)), 64'(STAT_ADR));
        issue_f(64'hFFFF_FFFF_FFFF_FFFF); t = cyc + 1;
        drain("ill_f_drain", 10);
        chk("ill_f_latency", 64'(last_f_dc - t), 64'd1);
        chk("ill_f_err", f_err, 1);
        chk("ill_f_rdata", f_rdata, 0);
        issue_f(64'd200);
        drain("ill_f_wr_drain", 10);
        chk("ill_wr_discarded", tmem[200 % DEPTH] === 64'h5555 ? 64'd1 : 64'd0, 64'd0);

        // Reset right after a read is accepted
        issue_f(64'd5);
        tick();
        chk("rst_mid_accept", mem_en, 1);
        rst_stage = 1'b1;
        tick();
        rst_stage = 1'b0;
        tick();
        chk("rst_mid_f_done", f_done, 0);
        chk("rst_mid_f_rdata", f_rdata, 0);
        chk("rst_mid_f_err", f_err, 0);
        chk("rst_mid_m_rdata", m_rdata, 0);
        chk("rst_mid_mem_en", mem_en, 0);
        repeat (3) tick();
        issue_f(64'd5); t = cyc + 1;
        drain("rst_fresh_drain", 20);
        chk("rst_fresh_latency", 64'(last_f_dc - t), 64'(MEM_LAT));
        chk("rst_fresh_data", f_rdata, 64'hDEAD_BEEF);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            if (!f_pend && $urandom_range(0, 2) == 0) issue_f(rand_addr());
            if (!m_pend && $urandom_range(0, 2) == 0) begin
                ic = icodes[$urandom_range(0, 5)];
                issue_m(icode_writes(ic), rand_addr(), {$urandom, $urandom});
            end
            rst_stage = ($urandom_range(0, 249) == 0);
            tick();
        end
        rst_stage = 1'b0;
        drain("rand_drain", 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
